key_event_ctrl: RTL and testbench
=================================

Name: key_event_ctrl

Overview:
- Parametrised successor to the fixed 5-key press/long-press detector.
- N_KEYS active-low keys are synchronised and debounced on both press and release, then classified as PRESS, LONG, CLICK (short press released) or RELEASE (long press released).
- Results go out as per-key level outputs and as a buffered event stream with a valid/ready handshake.
- Sits between the board key pins and the control FSM or UI logic.

Parameters:
- N_KEYS, 5: number of key inputs (1..16).
- DEBOUNCE_CYC, 30: clk cycles a level must be stable to be accepted (>=2).
- LONG_CYC, 1500: clk cycles from accepted press to LONG (> DEBOUNCE_CYC).
- CNT_W, 16: per-key counter width; LONG_CYC and REPEAT_CYC must fit.
- FIFO_DEPTH, 4: event FIFO entries (power of two, >=2).
- REPEAT_CYC, 200: auto-repeat period (used only with KEY_REPEAT_EN).

Ports:
- clk  in  1  system clock (all logic on posedge).
- rst  in  1  synchronous, active-high reset.
- key_n  in  N_KEYS  raw asynchronous keys, 0 = pressed.
- key_pressed  out  N_KEYS  debounced held level.
- key_long  out  N_KEYS  held for at least LONG_CYC.
- evt_valid  out  1  FIFO head valid.
- evt_ready  in  1  consumer accepts the head.
- evt_data  out  3+KIDX_W  {code[2:0], key_idx}; KIDX_W = clog2(N_KEYS), minimum 1.
- evt_overflow  out  1  sticky: an event was dropped.
- ovf_clr  in  1  clears evt_overflow.

Behaviour:
- Reset (rst=1 at a posedge):
  - Synchronisers go to all-ones; every channel FSM goes to IDLE; counters go to 0; pending flags clear; FIFO empties.
  - key_pressed=0, key_long=0, evt_valid=0, evt_data=0, evt_overflow=0.
  - A key held through reset is treated as a new press.
- Synchroniser: 2 flops per key. Latency is 2 cycles.
- Per-key FSM, driven by the synchronised level s:
  - IDLE: if s=0, go to DB_PRESS with cnt=0.
  - DB_PRESS: if s=1, return to IDLE with no event. Otherwise increment cnt. When cnt reaches DEBOUNCE_CYC-1, go to PRESSED, set key_pressed, raise event PRESS(0), and reset cnt to 0.
  - PRESSED: increment cnt. When cnt reaches LONG_CYC-DEBOUNCE_CYC-1, go to HELD_LONG, set key_long, raise event LONG(1). If s=1, go to DB_REL with cnt=0 and was_long=0.
  - HELD_LONG: if s=1, go to DB_REL with was_long=1.
  - DB_REL: if s=0, return to PRESSED or HELD_LONG according to was_long, with cnt=0 and no event. If s=1 for DEBOUNCE_CYC cycles, go to IDLE, clear key_pressed and key_long, and raise CLICK(2) if was_long=0, else RELEASE(3).
  - cnt saturates and never wraps.
- Timing: key_pressed rises exactly DEBOUNCE_CYC+2 cycles after the first low sample. key_long rises LONG_CYC+2 cycles after the first low sample.
- Event path:
  - Each channel has a 1-entry pending register. A raised event sets it.
  - The arbiter writes the lowest-index pending channel into the FIFO, one write per cycle, and clears that channel's pending flag.
  - If the FIFO is full, no write occurs and pending is held, even when a pop happens in the same cycle.
  - If a channel raises an event while its pending flag is already set, the new event is dropped and evt_overflow is set.
  - evt_overflow clears only on ovf_clr=1 or rst. If ovf_clr and a new drop occur in the same cycle, set wins.
- FIFO / handshake:
  - evt_valid = FIFO not empty.
  - Pop on evt_valid & evt_ready.
  - evt_data is stable while evt_valid=1 and evt_ready=0.
  - evt_data = 0 when the FIFO is empty.
  - Push into an empty FIFO appears on evt_valid the next cycle.
  - Events keep the order in which they were written.

Optional Feature:
- Macro: KEY_REPEAT_EN.
- Defined: in HELD_LONG, a per-key repeat counter emits REPEAT(4) every REPEAT_CYC cycles. The first REPEAT comes REPEAT_CYC cycles after LONG. The counter resets on entry to HELD_LONG and on a return from DB_REL.
- Undefined: no repeat counter is built, code 4 never appears, and REPEAT_CYC is ignored.

Decomposition:
- Shared package key_pkg:
  - Event code constants EVT_PRESS=0, EVT_LONG=1, EVT_CLICK=2, EVT_RELEASE=3, EVT_REPEAT=4.
  - Channel state enum {IDLE, DB_PRESS, PRESSED, HELD_LONG, DB_REL}.
  - Event code typedef, 3 bits.
- Sub-module key_channel: one instance per key, via a generate loop. It contains the synchroniser, FSM, counter, pending flag and repeat logic.
- Top level: arbiter, FIFO and overflow logic.

Test Plan:
Bench parameters for all cases: DEBOUNCE_CYC=4, LONG_CYC=20, FIFO_DEPTH=4, REPEAT_CYC=8, N_KEYS=5, evt_ready=1 unless stated.
- Bounce: key_n[1] low 2 cycles, high 1, low 3, then high -> no key_pressed and no event.
- Short press: key_n[0] low 10 cycles -> key_pressed[0] rises at cycle 6. Events {0,0} then {2,0}; key_long never set.
- Long press: key_n[3] low 40 cycles -> key_long[3] at cycle 22. Events {0,3}, {1,3}, {3,3}. With KEY_REPEAT_EN, {4,3} every 8 cycles while held.
- Simultaneous press: key_n[4] and key_n[2] pressed together -> PRESS for key 2 is written before key 4, in consecutive cycles.
- Backpressure/overflow: evt_ready=0 while 5 keys each give PRESS then CLICK -> FIFO holds 4 entries and evt_overflow=1. After ovf_clr, overflow clears; with evt_ready=1 the remaining events drain in order.
- Reset mid-press: assert rst while key 0 is in HELD_LONG, keep the key held -> outputs are 0. A fresh PRESS arrives 6 cycles after rst deasserts.

Source files
------------

// File: rtl/key_pkg.sv
// Shared event codes, channel state encoding and sizing helper for the key event controller.
package key_pkg;

  typedef logic [2:0] evt_code_t;

  localparam evt_code_t EVT_PRESS   = 3'd0;
  localparam evt_code_t EVT_LONG    = 3'd1;
  localparam evt_code_t EVT_CLICK   = 3'd2;
  localparam evt_code_t EVT_RELEASE = 3'd3;
  localparam evt_code_t EVT_REPEAT  = 3'd4;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DB_PRESS  = 3'd1,
    PRESSED   = 3'd2,
    HELD_LONG = 3'd3,
    DB_REL    = 3'd4
  } ch_state_e;

  // Key index width, never narrower than one bit.
  function automatic int unsigned kidx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_channel.sv
// One key: 2-flop synchroniser, press/release debounce FSM, long-press timer and pending event slot.
// With KEY_REPEAT_EN defined, a held long press also emits periodic REPEAT events.
module key_channel
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 30,
  parameter int unsigned LONG_CYC     = 1500,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned REPEAT_CYC   = 200
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      key_n_i,
  input  logic      grant_i,
  output logic      pressed_o,
  output logic      long_o,
  output logic      pend_o,
  output evt_code_t code_o,
  output logic      drop_o
);

  localparam logic [2:0] StIdle     = IDLE;
  localparam logic [2:0] StDbPress  = DB_PRESS;
  localparam logic [2:0] StPressed  = PRESSED;
  localparam logic [2:0] StHeldLong = HELD_LONG;
  localparam logic [2:0] StDbRel    = DB_REL;

  localparam logic [CNT_W-1:0] DbLast   = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] LongLast = CNT_W'(LONG_CYC - DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] CntMax   = '1;

  logic [1:0]       sync_q;
  logic             s;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             was_long_q, was_long_d;
  logic             pressed_q, pressed_d;
  logic             long_q, long_d;
  logic             pend_q, pend_d;
  evt_code_t        code_q, code_d;
  logic             fsm_raise;
  evt_code_t        fsm_code;
  logic             rep_fire;
  logic             evt_raise;
  evt_code_t        evt_code;

  assign s       = sync_q[1];
  assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    was_long_d = was_long_q;
    pressed_d  = pressed_q;
    long_d     = long_q;
    fsm_raise  = 1'b0;
    fsm_code   = EVT_PRESS;
    case (state_q)
      StIdle: begin
        if (!s) begin
          state_d = StDbPress;
          cnt_d   = '0;
        end
      end
      StDbPress: begin
        if (s) begin
          state_d = StIdle;
        end else if (cnt_q == DbLast) begin
          state_d   = StPressed;
          pressed_d = 1'b1;
          fsm_raise = 1'b1;
          fsm_code  = EVT_PRESS;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StPressed: begin
        // A release sample wins over the long-press deadline in the same cycle.
        if (s) begin
          state_d    = StDbRel;
          cnt_d      = '0;
          was_long_d = 1'b0;
        end else if (cnt_q == LongLast) begin
          state_d   = StHeldLong;
          long_d    = 1'b1;
          fsm_raise = 1'b1;
          fsm_code  = EVT_LONG;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StHeldLong: begin
        if (s) begin
          state_d    = StDbRel;
          cnt_d      = '0;
          was_long_d = 1'b1;
        end
      end
      StDbRel: begin
        if (!s) begin
          state_d = was_long_q ? StHeldLong : StPressed;
          cnt_d   = '0;
        end else if (cnt_q == DbLast) begin
          state_d   = StIdle;
          pressed_d = 1'b0;
          long_d    = 1'b0;
          fsm_raise = 1'b1;
          fsm_code  = was_long_q ? EVT_RELEASE : EVT_CLICK;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef KEY_REPEAT_EN
  localparam logic [CNT_W-1:0] RepLast = CNT_W'(REPEAT_CYC - 1);

  logic [CNT_W-1:0] rep_q, rep_d;

  // Held at zero outside HELD_LONG, so both entry and a bounce return restart the period.
  always_comb begin
    rep_d    = rep_q;
    rep_fire = 1'b0;
    if (state_q != StHeldLong || s) begin
      rep_d = '0;
    end else if (rep_q == RepLast) begin
      rep_fire = 1'b1;
      rep_d    = '0;
    end else begin
      rep_d = rep_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) rep_q <= '0;
    else       rep_q <= rep_d;
  end
`else
  logic unused_repeat_cyc;
  assign unused_repeat_cyc = ^REPEAT_CYC;
  assign rep_fire          = 1'b0;
`endif

  assign evt_raise = fsm_raise | rep_fire;
  assign evt_code  = rep_fire ? EVT_REPEAT : fsm_code;

  // An occupied slot drops the new event even if it is being drained this cycle.
  always_comb begin
    pend_d = pend_q & ~grant_i;
    code_d = code_q;
    drop_o = evt_raise & pend_q;
    if (evt_raise && !pend_q) begin
      pend_d = 1'b1;
      code_d = evt_code;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q     <= 2'b11;
      state_q    <= StIdle;
      cnt_q      <= '0;
      was_long_q <= 1'b0;
      pressed_q  <= 1'b0;
      long_q     <= 1'b0;
      pend_q     <= 1'b0;
      code_q     <= EVT_PRESS;
    end else begin
      sync_q     <= {sync_q[0], key_n_i};
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      was_long_q <= was_long_d;
      pressed_q  <= pressed_d;
      long_q     <= long_d;
      pend_q     <= pend_d;
      code_q     <= code_d;
    end
  end

  assign pressed_o = pressed_q;
  assign long_o    = long_q;
  assign pend_o    = pend_q;
  assign code_o    = code_q;

endmodule

// File: rtl/key_event_ctrl.sv
// Key event controller: per-key channels, lowest-index arbiter, event FIFO and sticky overflow.
// Define KEY_REPEAT_EN to add REPEAT events during a held long press.
module key_event_ctrl
  import key_pkg::*;
#(
  parameter int unsigned N_KEYS       = 5,
  parameter int unsigned DEBOUNCE_CYC = 30,
  parameter int unsigned LONG_CYC     = 1500,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned REPEAT_CYC   = 200,
  localparam int unsigned KIDX_W      = kidx_w(N_KEYS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_n,
  output logic [N_KEYS-1:0] key_pressed,
  output logic [N_KEYS-1:0] key_long,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [KIDX_W+2:0] evt_data,
  output logic              evt_overflow,
  input  logic              ovf_clr
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned EVT_W = KIDX_W + 3;

  logic [N_KEYS-1:0] pend, drop, grant, sel_oh;
  evt_code_t         codes [N_KEYS];
  logic              sel_valid;
  logic [KIDX_W-1:0] sel_idx;
  evt_code_t         sel_code;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    key_channel #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .LONG_CYC    (LONG_CYC),
      .CNT_W       (CNT_W),
      .REPEAT_CYC  (REPEAT_CYC)
    ) u_ch (
      .clk_i    (clk),
      .rst_i    (rst),
      .key_n_i  (key_n[g]),
      .grant_i  (grant[g]),
      .pressed_o(key_pressed[g]),
      .long_o   (key_long[g]),
      .pend_o   (pend[g]),
      .code_o   (codes[g]),
      .drop_o   (drop[g])
    );
  end

  // Scan from the top so the lowest pending index is the one left selected.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    sel_code  = EVT_PRESS;
    sel_oh    = '0;
    for (int i = int'(N_KEYS) - 1; i >= 0; i--) begin
      if (pend[i]) begin
        sel_valid = 1'b1;
        sel_idx   = KIDX_W'(i);
        sel_code  = codes[i];
        sel_oh    = '0;
        sel_oh[i] = 1'b1;
      end
    end
  end

  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic [EVT_W-1:0] mem_q [FIFO_DEPTH];
  logic             full, push, pop;

  // Fullness is judged before any same-cycle pop.
  assign full      = (count_q == (PTR_W + 1)'(FIFO_DEPTH));
  assign push      = sel_valid & ~full;
  assign evt_valid = (count_q != '0);
  assign pop       = evt_valid & evt_ready;
  assign grant     = push ? sel_oh : '0;
  assign evt_data  = evt_valid ? mem_q[rd_ptr_q] : '0;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {sel_code, sel_idx};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  logic ovf_q;

  always_ff @(posedge clk) begin
    if (rst)          ovf_q <= 1'b0;
    else if (|drop)   ovf_q <= 1'b1;
    else if (ovf_clr) ovf_q <= 1'b0;
  end

  assign evt_overflow = ovf_q;

endmodule

// File: tb/tb_key_event_ctrl.sv
// Randomised bench for key_event_ctrl with a timestamp-based reference model and event scoreboard.
module tb_key_event_ctrl;

  localparam int N     = 5;
  localparam int DEB   = 4;
  localparam int LNG   = 20;
  localparam int DEPTH = 4;
  localparam int REP   = 8;
  localparam int KW    = 3;
  localparam int EW    = KW + 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  key_n = '1;
  logic [N-1:0]  key_pressed, key_long;
  logic          evt_valid;
  logic          evt_ready = 1'b1;
  logic [EW-1:0] evt_data;
  logic          evt_overflow;
  logic          ovf_clr = 1'b0;

  key_event_ctrl #(
    .N_KEYS      (N),
    .DEBOUNCE_CYC(DEB),
    .LONG_CYC    (LNG),
    .CNT_W       (16),
    .FIFO_DEPTH  (DEPTH),
    .REPEAT_CYC  (REP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_n       (key_n),
    .key_pressed (key_pressed),
    .key_long    (key_long),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_data    (evt_data),
    .evt_overflow(evt_overflow),
    .ovf_clr     (ovf_clr)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  bit mon_en      = 1'b0;

  // Reference model: key levels are tracked as run lengths and timestamps.
  int           now = 0;
  logic [N-1:0] m_s1 = '1, m_s2 = '1;
  bit           m_pressed [N];
  bit           m_long    [N];
  bit           m_rel     [N];
  int           m_lowrun  [N];
  int           m_highrun [N];
  int           m_anchor  [N];
  bit           m_pend    [N];
  int           m_pcode   [N];
  int           m_count = 0;
  bit           m_ovf   = 1'b0;
  logic [EW-1:0] exp_q [$];
  int           timer [N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic key_step(input int k, input logic s, output bit raised, output int code);
    raised = 1'b0;
    code   = 0;
    if (!m_pressed[k]) begin
      m_lowrun[k] = s ? 0 : m_lowrun[k] + 1;
      if (m_lowrun[k] == DEB + 1) begin
        m_pressed[k] = 1'b1;
        m_anchor[k]  = now;
        m_lowrun[k]  = 0;
        raised = 1'b1;
        code   = 0;
      end
    end else if (s) begin
      m_highrun[k] = m_rel[k] ? m_highrun[k] + 1 : 1;
      m_rel[k]     = 1'b1;
      if (m_highrun[k] == DEB + 1) begin
        raised = 1'b1;
        code   = m_long[k] ? 3 : 2;
        m_pressed[k] = 1'b0;
        m_long[k]    = 1'b0;
        m_rel[k]     = 1'b0;
        m_lowrun[k]  = 0;
      end
    end else if (m_rel[k]) begin
      m_rel[k]    = 1'b0;
      m_anchor[k] = now;
    end else if (!m_long[k]) begin
      if (now - m_anchor[k] == LNG - DEB) begin
        m_long[k]   = 1'b1;
        m_anchor[k] = now;
        raised = 1'b1;
        code   = 1;
      end
    end
`ifdef KEY_REPEAT_EN
    else if (now - m_anchor[k] == REP) begin
      m_anchor[k] = now;
      raised = 1'b1;
      code   = 4;
    end
`endif
  endtask

  task automatic model_step();
    bit   pend_pre [N];
    bit   raised, pop, push, drop;
    int   code, sel;
    now++;
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        m_pressed[k] = 1'b0; m_long[k] = 1'b0; m_rel[k] = 1'b0;
        m_lowrun[k] = 0; m_highrun[k] = 0; m_anchor[k] = 0;
        m_pend[k] = 1'b0; m_pcode[k] = 0;
      end
      m_s1 = '1;
      m_s2 = '1;
      m_count = 0;
      m_ovf = 1'b0;
      exp_q.delete();
      return;
    end
    for (int k = 0; k < N; k++) pend_pre[k] = m_pend[k];
    sel = -1;
    for (int k = N - 1; k >= 0; k--) if (m_pend[k]) sel = k;
    pop  = (m_count > 0) && evt_ready;
    push = (sel >= 0) && (m_count < DEPTH);
    if (push) begin
      exp_q.push_back({3'(m_pcode[sel]), KW'(sel)});
      m_pend[sel] = 1'b0;
    end
    m_count = m_count + int'(push) - int'(pop);
    drop = 1'b0;
    for (int k = 0; k < N; k++) begin
      key_step(k, m_s2[k], raised, code);
      if (raised) begin
        if (pend_pre[k]) begin
          drop = 1'b1;
        end else begin
          m_pend[k]  = 1'b1;
          m_pcode[k] = code;
        end
      end
    end
    if (drop)         m_ovf = 1'b1;
    else if (ovf_clr) m_ovf = 1'b0;
    m_s2 = m_s1;
    m_s1 = key_n;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  function automatic logic [N-1:0] pack(input bit a [N]);
    logic [N-1:0] v;
    for (int k = 0; k < N; k++) v[k] = a[k];
    return v;
  endfunction

  // Monitor: outputs and the pending handshake are stable between negedge drive and next posedge.
  initial forever begin
    @(negedge clk);
    #1;
    if (mon_en) begin
      check("key_pressed", 32'(key_pressed), 32'(pack(m_pressed)));
      check("key_long", 32'(key_long), 32'(pack(m_long)));
      check("evt_valid", 32'(evt_valid), 32'(m_count > 0));
      check("evt_overflow", 32'(evt_overflow), 32'(m_ovf));
      if (!evt_valid) begin
        check("evt_data_idle", 32'(evt_data), 32'd0);
      end else if (evt_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL evt_unexpected at t=%0t: got %0h expected none", $time, evt_data);
        end else begin
          check("evt_data", 32'(evt_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [N-1:0] mask, input int n);
    key_n = key_n & ~mask;
    cyc(n);
    key_n = key_n | mask;
  endtask

  initial begin
    cyc(3);
    rst    = 1'b0;
    mon_en = 1'b1;
    #1;
    check("rst_pressed", 32'(key_pressed), 32'd0);
    check("rst_long", 32'(key_long), 32'd0);
    check("rst_valid", 32'(evt_valid), 32'd0);
    check("rst_data", 32'(evt_data), 32'd0);
    check("rst_ovf", 32'(evt_overflow), 32'd0);

    // Bounce on key 1: never stable long enough
    key_n[1] = 1'b0; cyc(2);
    key_n[1] = 1'b1; cyc(1);
    key_n[1] = 1'b0; cyc(3);
    key_n[1] = 1'b1; cyc(20);

    press(5'b00001, 10); cyc(30);   // short press -> PRESS, CLICK
    press(5'b01000, 40); cyc(40);   // long press -> PRESS, LONG, (REPEAT), RELEASE
    press(5'b10100, 10); cyc(30);   // simultaneous keys 2 and 4

    // Backpressure until the FIFO fills and an event is dropped
    evt_ready = 1'b0;
    press(5'b11111, 10); cyc(30);
    check("bp_ovf_set", 32'(evt_overflow), 32'd1);
    check("bp_fifo_full", 32'(evt_valid), 32'd1);
    ovf_clr = 1'b1; cyc(1);
    ovf_clr = 1'b0;
    evt_ready = 1'b1; cyc(30);

    // Reset while key 0 sits in a long hold, key kept low throughout
    key_n[0] = 1'b0; cyc(30);
    rst = 1'b1; cyc(2);
    rst = 1'b0; cyc(15);
    key_n[0] = 1'b1; cyc(30);

    // Randomised phase
    for (int k = 0; k < N; k++) timer[k] = 10 + k;
    for (int c = 0; c < 6000; c++) begin
      for (int k = 0; k < N; k++) begin
        if (timer[k] == 0) begin
          key_n[k] = ~key_n[k];
          timer[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 45);
        end else begin
          timer[k]--;
        end
      end
      evt_ready = ($urandom_range(0, 3) != 0);
      ovf_clr   = ($urandom_range(0, 40) == 0);
      rst       = ($urandom_range(0, 2999) == 0);
      cyc(1);
    end

    key_n     = '1;
    rst       = 1'b0;
    ovf_clr   = 1'b0;
    evt_ready = 1'b1;
    cyc(80);
    #1;
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    check("drain_valid", 32'(evt_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
